// File: rtl/data_ram_resp.sv
// Data RAM with one-cycle read-first response plus a small MMIO page (LED, SW, timer).
// Define DATA_RAM_TIMER_EN to build the COUNT/COMPARE/TSTAT timer; otherwise it is absent.
module data_ram_resp #(
    parameter int RAM_AW = 10
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam logic [15:0] MMIO_PAGE  = 16'hBFAF;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_SW     = 16'hF004;
    localparam logic [15:0] OFF_COUNT  = 16'hF008;
    localparam logic [15:0] OFF_CMP    = 16'hF00C;
    localparam logic [15:0] OFF_TSTAT  = 16'hF010;

    logic [31:0]       ram_r [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx_s;
    logic              mmio_sel_s;
    logic              ram_wr_s;
    logic              mmio_wr_s;
    logic [31:0]       mmio_rdata_s;
    logic [15:0]       led_r;
    logic [15:0]       sw_meta_r;
    logic [15:0]       sw_sync_r;

    assign ram_idx_s  = daddr[RAM_AW+1:2];
    assign mmio_sel_s = (daddr[31:16] == MMIO_PAGE);
    assign ram_wr_s   = dce && !mmio_sel_s && (we != 4'h0);
    // Only full-word stores reach MMIO registers.
    assign mmio_wr_s  = dce && mmio_sel_s && (we == 4'hF);
    assign led        = led_r;

`ifdef DATA_RAM_TIMER_EN
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pend_r;
    logic        match_s;

    assign match_s   = (count_r == compare_r) && (compare_r != 32'h0000_0000);
    assign timer_irq = pend_r;

    // Free-running counter, compare register and sticky pending flag
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            count_r   <= 32'h0000_0000;
            compare_r <= 32'h0000_0000;
            pend_r    <= 1'b0;
        end else begin
            if (mmio_wr_s && (daddr[15:0] == OFF_COUNT)) begin
                count_r <= din;
            end else begin
                count_r <= count_r + 32'd1;
            end
            if (mmio_wr_s && (daddr[15:0] == OFF_CMP)) begin
                compare_r <= din;
            end
            // A new match outranks a simultaneous software clear.
            if (match_s) begin
                pend_r <= 1'b1;
            end else if (mmio_wr_s && (daddr[15:0] == OFF_TSTAT) && din[0]) begin
                pend_r <= 1'b0;
            end
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    // MMIO read mux on current (pre-write) register values
    always_comb begin
        mmio_rdata_s = 32'h0000_0000;
        case (daddr[15:0])
            OFF_LED:   mmio_rdata_s = {16'h0000, led_r};
            OFF_SW:    mmio_rdata_s = {16'h0000, sw_sync_r};
`ifdef DATA_RAM_TIMER_EN
            OFF_COUNT: mmio_rdata_s = count_r;
            OFF_CMP:   mmio_rdata_s = compare_r;
            OFF_TSTAT: mmio_rdata_s = {31'h0000_0000, pend_r};
`endif
            default:   mmio_rdata_s = 32'h0000_0000;
        endcase
    end

    // RAM byte-lane writes; contents survive reset, but no write lands while reset is held
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n && ram_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    ram_r[ram_idx_s][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    // Read-data register: captures on enabled accesses, holds otherwise
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            dm <= 32'h0000_0000;
        end else if (dce) begin
            dm <= mmio_sel_s ? mmio_rdata_s : ram_r[ram_idx_s];
        end
    end

    // LED register and two-flop switch synchronizer
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            led_r     <= 16'h0000;
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
            if (mmio_wr_s && (daddr[15:0] == OFF_LED)) begin
                led_r <= din[15:0];
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios plus randomized traffic
// checked every cycle against a word-array/register reference model.
module tb_data_ram_resp;

`ifdef DATA_RAM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dce = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [3:0]  we = 4'h0;
    logic [31:0] din = 32'h0;
    logic [15:0] sw = 16'h0;
    logic [31:0] dm;
    logic [15:0] led;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [0:1023];
    logic [31:0] m_dm = 32'h0;
    logic [15:0] m_led = 16'h0, m_sw1 = 16'h0, m_sw2 = 16'h0;
    logic [31:0] m_count = 32'h0, m_cmp = 32'h0;
    logic        m_pend = 1'b0;

    data_ram_resp #(.RAM_AW(10)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .dce(dce), .daddr(daddr),
        .we(we), .din(din), .dm(dm), .sw(sw), .led(led), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dm = 32'h0; m_led = 16'h0; m_sw1 = 16'h0; m_sw2 = 16'h0;
        m_count = 32'h0; m_cmp = 32'h0; m_pend = 1'b0;
    endtask

    // Called at a negedge: drive, advance model one edge, check after the posedge, return at next negedge.
    task automatic cycle(input logic d, input logic [31:0] a, input logic [3:0] w, input logic [31:0] di);
        logic        mmio, wr, hit;
        logic [15:0] off;
        logic [31:0] rd, nxt_count;
        dce = d; daddr = a; we = w; din = di;
        mmio = (a[31:16] == 16'hBFAF);
        off  = a[15:0];
        rd   = 32'h0;
        if (mmio) begin
            case (off)
                16'hF000: rd = {16'h0, m_led};
                16'hF004: rd = {16'h0, m_sw2};
                16'hF008: rd = TIMER_EN ? m_count : 32'h0;
                16'hF00C: rd = TIMER_EN ? m_cmp : 32'h0;
                16'hF010: rd = {31'h0, m_pend};
                default:  rd = 32'h0;
            endcase
        end else begin
            rd = m_mem[a[11:2]];
        end
        hit = TIMER_EN && (m_count == m_cmp) && (m_cmp != 32'h0);
        if (d) m_dm = rd;
        if (d && !mmio) begin
            for (int b = 0; b < 4; b++)
                if (w[b]) m_mem[a[11:2]][8*b +: 8] = di[8*b +: 8];
        end
        wr = d && mmio && (w == 4'hF);
        m_sw2 = m_sw1;
        m_sw1 = sw;
        if (wr && off == 16'hF000) m_led = di[15:0];
        nxt_count = (wr && off == 16'hF008) ? di : m_count + 32'd1;
        if (wr && off == 16'hF00C) m_cmp = di;
        if (hit) m_pend = 1'b1;
        else if (wr && off == 16'hF010 && di[0]) m_pend = 1'b0;
        m_count = nxt_count;
        @(posedge clk);
        #1;
        chk("dm", dm, m_dm);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_pend});
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, di;
        logic [3:0]  w;
        logic [15:0] offs [6];
        int          seen;
        offs = '{16'hF000, 16'hF004, 16'hF008, 16'hF00C, 16'hF010, 16'hF014};

        // Reset state while held
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dm", dm, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_irq", {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-fill RAM so every later read has a known value
        for (int i = 0; i < 1024; i++) cycle(1'b1, i * 4, 4'hF, 32'h0);

        // Full write, read, alias read
        cycle(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678);
        cycle(1'b1, 32'h0000_0010, 4'h0, 32'h0);
        chk("read_0x10", dm, 32'h1234_5678);
        cycle(1'b1, 32'h0000_1010, 4'h0, 32'h0);
        chk("alias_0x1010", dm, 32'h1234_5678);
        // Single lane write
        cycle(1'b1, 32'h0000_0010, 4'b0100, 32'hAABB_CCDD);
        cycle(1'b1, 32'h0000_0010, 4'h0, 32'h0);
        chk("lane2_write", dm, 32'h12BB_5678);
        // Read-first on simultaneous read/write
        cycle(1'b1, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF);
        chk("read_first", dm, 32'h0);
        idle();
        chk("dm_hold", dm, 32'h0);
        cycle(1'b1, 32'h0000_0020, 4'h0, 32'h0);
        chk("after_write", dm, 32'hFFFF_FFFF);

        // LED / SW MMIO
        cycle(1'b1, 32'hBFAF_F000, 4'hF, 32'h0001_A5A5);
        chk("led_value", {16'h0, led}, 32'h0000_A5A5);
        sw = 16'h00FF;
        repeat (3) idle();
        cycle(1'b1, 32'hBFAF_F000, 4'h0, 32'h0);
        chk("led_read", dm, 32'h0000_A5A5);
        cycle(1'b1, 32'hBFAF_F004, 4'h0, 32'h0);
        chk("sw_read", dm, 32'h0000_00FF);
        cycle(1'b1, 32'hBFAF_F000, 4'b0011, 32'h0000_1111);
        chk("led_partial", {16'h0, led}, 32'h0000_A5A5);
        cycle(1'b1, 32'hBFAF_F020, 4'hF, 32'hFFFF_FFFF);
        cycle(1'b1, 32'hBFAF_F020, 4'h0, 32'h0);
        chk("unmapped_read", dm, 32'h0);

        // Timer wrap and interrupt
        cycle(1'b1, 32'hBFAF_F008, 4'hF, 32'hFFFF_FFFE);
        cycle(1'b1, 32'hBFAF_F00C, 4'hF, 32'h0000_0003);
        seen = 0;
        for (int i = 1; i <= 12; i++) begin
            idle();
            if (timer_irq && seen == 0) seen = i;
        end
        if (TIMER_EN) begin
            chk("irq_latency", seen, 32'd5);
            cycle(1'b1, 32'hBFAF_F010, 4'hF, 32'h0000_0001);
            chk("tstat_clear", {31'h0, timer_irq}, 32'h0);
            // Re-arm so pending is set going into the reset test
            cycle(1'b1, 32'hBFAF_F00C, 4'hF, m_count + 32'd3);
            repeat (6) idle();
            chk("irq_rearmed", {31'h0, timer_irq}, 32'h1);
        end else begin
            chk("irq_disabled", seen, 32'd0);
            cycle(1'b1, 32'hBFAF_F008, 4'h0, 32'h0);
            chk("count_disabled", dm, 32'h0);
        end

        // Async reset in the middle of a read+write access
        cycle(1'b1, 32'h0000_0010, 4'h0, 32'h0);
        dce = 1'b1; daddr = 32'h0000_0040; we = 4'hF; din = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        chk("async_dm", dm, 32'h0);
        chk("async_led", {16'h0, led}, 32'h0);
        chk("async_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        dce = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 32'h0000_0040, 4'h0, 32'h0);
        chk("dropped_write", dm, 32'h0);

        // Randomized mixed traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                a = $urandom;
                if (a[31:16] == 16'hBFAF) a[30] = 1'b1;
                w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                cycle($urandom_range(0, 3) != 0, a, w, $urandom);
            end else begin
                a = {16'hBFAF, offs[$urandom_range(0, 5)]};
                w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                di = $urandom;
                cycle($urandom_range(0, 3) != 0, a, w, di);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
